// File: rtl/image_sdram_writer.sv
`default_nettype none
// ============================================================================
// Module      : image_sdram_writer
// Description : Writes background/mask RGB pixel pairs from the image download
//               path into SDRAM using the interleaved layout the line reader
//               expects: three 16-bit words per pixel, ordered R, G, B, each
//               word {mask byte, background byte}. Runs in clk_sys_131_072.
// Ports       : clk, reset        - system clock, async active-high reset
//               start, base_addr  - begin (or restart) a frame at base_addr
//               pixel_valid/ready - pixel pair handshake (background_rgb,
//                                   mask_rgb)
//               sd_wr_req/ready   - SDRAM write handshake (sd_addr, sd_data)
//               busy, done        - frame in progress / end-of-frame pulse
//               checksum          - 16-bit wrapping sum of accepted words
// Options     : IMAGE_WRITER_CHECKSUM_EN - define to build the checksum
//               adder; otherwise checksum is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module image_sdram_writer #(
  parameter int LINE_PIXELS = 720,
  parameter int LINES       = 720,
  parameter int ADDR_WIDTH  = 25
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  pixel_valid,
  output logic                  pixel_ready,
  input  logic [23:0]           background_rgb,
  input  logic [23:0]           mask_rgb,
  output logic                  sd_wr_req,
  input  logic                  sd_ready,
  output logic [ADDR_WIDTH-1:0] sd_addr,
  output logic [15:0]           sd_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           checksum
);

  localparam int c_X_W = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int c_Y_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [c_X_W-1:0] c_X_LAST = c_X_W'(LINE_PIXELS - 1);
  localparam logic [c_Y_W-1:0] c_Y_LAST = c_Y_W'(LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_W0    = 3'd2,
    S_W1    = 3'd3,
    S_W2    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_pixel_ready, w_pixel_ready_nxt;
  logic                    r_sd_wr_req, w_sd_wr_req_nxt;
  logic [ADDR_WIDTH-1:0]   r_sd_addr, w_sd_addr_nxt;
  logic [15:0]             r_sd_data, w_sd_data_nxt;
  logic                    r_busy, w_busy_nxt;
  logic [c_X_W-1:0]        r_x, w_x_nxt;
  logic [c_Y_W-1:0]        r_y, w_y_nxt;
  logic [23:0]             r_bg, w_bg_nxt;
  logic [23:0]             r_mask, w_mask_nxt;
  logic                    w_last_pixel;
  logic                    w_word_accepted;

  assign w_last_pixel    = (r_x == c_X_LAST) && (r_y == c_Y_LAST);
  assign w_word_accepted = r_sd_wr_req && sd_ready;

  // Next-state and registered-output computation. Outputs are registered, so
  // each branch sets the value the output must carry in the *next* state.
  always_comb begin
    w_state_nxt       = r_state;
    w_pixel_ready_nxt = 1'b0;
    w_sd_wr_req_nxt   = 1'b0;
    w_sd_addr_nxt     = r_sd_addr;
    w_sd_data_nxt     = r_sd_data;
    w_busy_nxt        = r_busy;
    w_x_nxt           = r_x;
    w_y_nxt           = r_y;
    w_bg_nxt          = r_bg;
    w_mask_nxt        = r_mask;

    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
      end

      S_FETCH: begin
        if (pixel_valid) begin
          // R word comes straight from the inputs so W0 starts immediately.
          w_bg_nxt        = background_rgb;
          w_mask_nxt      = mask_rgb;
          w_sd_data_nxt   = {mask_rgb[23:16], background_rgb[23:16]};
          w_sd_wr_req_nxt = 1'b1;
          w_state_nxt     = S_W0;
        end else begin
          w_pixel_ready_nxt = 1'b1;
        end
      end

      S_W0: begin
        w_sd_wr_req_nxt = 1'b1;
        if (sd_ready) begin
          w_sd_addr_nxt = r_sd_addr + ADDR_WIDTH'(1);
          w_sd_data_nxt = {r_mask[15:8], r_bg[15:8]};
          w_state_nxt   = S_W1;
        end
      end

      S_W1: begin
        w_sd_wr_req_nxt = 1'b1;
        if (sd_ready) begin
          w_sd_addr_nxt = r_sd_addr + ADDR_WIDTH'(1);
          w_sd_data_nxt = {r_mask[7:0], r_bg[7:0]};
          w_state_nxt   = S_W2;
        end
      end

      S_W2: begin
        w_sd_wr_req_nxt = 1'b1;
        if (sd_ready) begin
          w_sd_wr_req_nxt = 1'b0;
          w_sd_addr_nxt   = r_sd_addr + ADDR_WIDTH'(1);
          if (w_last_pixel) begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_DONE;
          end else begin
            w_pixel_ready_nxt = 1'b1;
            w_state_nxt       = S_FETCH;
            if (r_x == c_X_LAST) begin
              w_x_nxt = '0;
              w_y_nxt = r_y + c_Y_W'(1);
            end else begin
              w_x_nxt = r_x + c_X_W'(1);
            end
          end
        end
      end

      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase

    // A start from any state restarts the frame; any partially written pixel
    // is abandoned and the pending write request is withdrawn.
    if (start) begin
      w_state_nxt       = S_FETCH;
      w_pixel_ready_nxt = 1'b1;
      w_sd_wr_req_nxt   = 1'b0;
      w_sd_addr_nxt     = base_addr;
      w_busy_nxt        = 1'b1;
      w_x_nxt           = '0;
      w_y_nxt           = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pixel_ready <= 1'b0;
      r_sd_wr_req   <= 1'b0;
      r_sd_addr     <= '0;
      r_sd_data     <= '0;
      r_busy        <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_bg          <= '0;
      r_mask        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pixel_ready <= w_pixel_ready_nxt;
      r_sd_wr_req   <= w_sd_wr_req_nxt;
      r_sd_addr     <= w_sd_addr_nxt;
      r_sd_data     <= w_sd_data_nxt;
      r_busy        <= w_busy_nxt;
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_bg          <= w_bg_nxt;
      r_mask        <= w_mask_nxt;
    end
  end

`ifdef IMAGE_WRITER_CHECKSUM_EN
  logic [15:0] r_checksum;

  // Start clears the sum even if a word is accepted in the same cycle; that
  // word belongs to the abandoned frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (start) begin
      r_checksum <= '0;
    end else if (w_word_accepted) begin
      r_checksum <= r_checksum + r_sd_data;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign pixel_ready = r_pixel_ready;
  assign sd_wr_req   = r_sd_wr_req;
  assign sd_addr     = r_sd_addr;
  assign sd_data     = r_sd_data;
  assign busy        = r_busy;
  // Suppressed when a restart lands on the DONE cycle: that frame is replaced.
  assign done        = (r_state == S_DONE) && !start;

endmodule
`default_nettype wire

// File: tb/tb_image_sdram_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_sdram_writer
// Description : Self-checking bench for image_sdram_writer on a small 3x2
//               frame. Expected writes are derived from the pixel list and
//               the word layout (address = base + 3*pixel + colour).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_sdram_writer;

  localparam int LP     = 3;
  localparam int LN     = 2;
  localparam int AW     = 25;
  localparam int NPIX   = LP * LN;
  localparam int NWORDS = NPIX * 3;
  localparam int BUDGET = 2000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          pixel_valid;
  logic          pixel_ready;
  logic [23:0]   background_rgb;
  logic [23:0]   mask_rgb;
  logic          sd_wr_req;
  logic          sd_ready;
  logic [AW-1:0] sd_addr;
  logic [15:0]   sd_data;
  logic          busy;
  logic          done;
  logic [15:0]   checksum;

  int checks   = 0;
  int failures = 0;

  logic [23:0]   px_bg [NPIX];
  logic [23:0]   px_mk [NPIX];
  logic [AW-1:0] exp_addr [NWORDS];
  logic [15:0]   exp_data [NWORDS];

  always #5 clk = ~clk;

  image_sdram_writer #(
    .LINE_PIXELS(LP),
    .LINES      (LN),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .pixel_valid   (pixel_valid),
    .pixel_ready   (pixel_ready),
    .background_rgb(background_rgb),
    .mask_rgb      (mask_rgb),
    .sd_wr_req     (sd_wr_req),
    .sd_ready      (sd_ready),
    .sd_addr       (sd_addr),
    .sd_data       (sd_data),
    .busy          (busy),
    .done          (done),
    .checksum      (checksum)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ck_exp(input logic [15:0] s);
`ifdef IMAGE_WRITER_CHECKSUM_EN
    return s;
`else
    return 16'h0000 & s;
`endif
  endfunction

  // Word k of the frame: pixel k/3, colour k%3 (R,G,B), {mask byte, bg byte}.
  task automatic build_expected(input logic [AW-1:0] base);
    for (int p = 0; p < NPIX; p++) begin
      for (int c = 0; c < 3; c++) begin
        logic [23:0] m;
        logic [23:0] b;
        m = px_mk[p];
        b = px_bg[p];
        exp_addr[3*p+c] = base + AW'(3*p + c);
        exp_data[3*p+c] = {m[23-8*c -: 8], b[23-8*c -: 8]};
      end
    end
  endtask

  task automatic run_frame(input logic [AW-1:0] base, input int ready_pct,
                           input int valid_pct, input bit abort_first, input bit directed);
    int          px_idx   = 0;
    int          w_idx    = 0;
    int          last_cyc = -1;
    int          done_cyc = -1;
    int          done_cnt = 0;
    bit          stalled  = 1'b0;
    bit          found    = 1'b0;
    logic [15:0] run_sum  = 16'h0;
    logic [AW-1:0] hold_addr = '0;
    logic [15:0]   hold_data = '0;

    for (int p = 0; p < NPIX; p++) begin
      px_bg[p] = 24'($urandom);
      px_mk[p] = 24'($urandom);
    end
    if (directed) begin
      px_bg[0] = 24'h112233; px_mk[0] = 24'hAABBCC;
      px_bg[1] = 24'h445566; px_mk[1] = 24'hDDEEFF;
    end
    build_expected(base);

    if (abort_first) begin
      // Launch a frame at 0, then restart it while pixel 0's G word is pending.
      @(negedge clk);
      base_addr = '0; start = 1'b1; sd_ready = 1'b1; pixel_valid = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        start = 1'b0;
        if (sd_wr_req && sd_addr == AW'(1)) begin
          found = 1'b1;
          sd_ready = 1'b0; pixel_valid = 1'b0;
          start = 1'b1; base_addr = base;
          break;
        end
        sd_ready = 1'b1; pixel_valid = 1'b1;
        background_rgb = 24'($urandom); mask_rgb = 24'($urandom);
      end
      check("abort_reach_w1", 32'(found), 32'd1);
    end else begin
      @(negedge clk);
      base_addr = base; start = 1'b1; sd_ready = 1'b0; pixel_valid = 1'b0;
    end

    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      check("checksum_running", 32'(checksum), 32'(ck_exp(run_sum)));
      if (directed && w_idx == 6 && last_cyc == cyc - 1)
        check("checksum_basic", 32'(checksum),
              32'(ck_exp(16'(32'hAA11 + 32'hBB22 + 32'hCC33 + 32'hDD44 + 32'hEE55 + 32'hFF66))));
      if (stalled) begin
        check("hold_req", 32'(sd_wr_req), 32'd1);
        check("hold_addr", 32'(sd_addr), 32'(hold_addr));
        check("hold_data", 32'(sd_data), 32'(hold_data));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_word_count", 32'(w_idx), 32'(NWORDS));
        check("done_after_last", 32'(cyc), 32'(last_cyc + 1));
        check("busy_at_done", 32'(busy), 32'd0);
        break;
      end
      if (pixel_ready && sd_wr_req) check("ready_during_write", 32'd1, 32'd0);

      sd_ready    = ($urandom_range(0, 99) < ready_pct);
      pixel_valid = (px_idx < NPIX) && ($urandom_range(0, 99) < valid_pct);
      if (pixel_valid) begin
        background_rgb = px_bg[px_idx];
        mask_rgb       = px_mk[px_idx];
      end else begin
        background_rgb = 24'($urandom);
        mask_rgb       = 24'($urandom);
      end
      if (pixel_valid && pixel_ready) px_idx++;

      if (sd_wr_req && sd_ready) begin
        if (w_idx < NWORDS) begin
          check("wr_addr", 32'(sd_addr), 32'(exp_addr[w_idx]));
          check("wr_data", 32'(sd_data), 32'(exp_data[w_idx]));
          run_sum = run_sum + exp_data[w_idx];
        end else begin
          check("extra_write", 32'd1, 32'd0);
        end
        w_idx++;
        last_cyc = cyc;
        stalled  = 1'b0;
      end else if (sd_wr_req) begin
        stalled   = 1'b1;
        hold_addr = sd_addr;
        hold_data = sd_data;
      end else begin
        stalled = 1'b0;
      end
    end

    check("done_seen", 32'(done_cnt), 32'd1);
    if (ready_pct == 100 && valid_pct == 100)
      check("frame_latency", 32'(done_cyc), 32'(1 + 4 * NPIX));

    // After the frame nothing further may be requested or written.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pixel_valid = 1'b1; sd_ready = 1'b1;
      check("post_pixel_ready", 32'(pixel_ready), 32'd0);
      check("post_wr_req", 32'(sd_wr_req), 32'd0);
      check("post_busy", 32'(busy), 32'd0);
      check("post_done", 32'(done), 32'd0);
      check("post_checksum", 32'(checksum), 32'(ck_exp(run_sum)));
    end
    pixel_valid = 1'b0;
  endtask

  task automatic reset_mid_w2(input logic [AW-1:0] base);
    bit found = 1'b0;
    @(negedge clk);
    base_addr = base; start = 1'b1; sd_ready = 1'b1; pixel_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (sd_wr_req && sd_addr == base + AW'(2)) begin
        found = 1'b1;
        break;
      end
      sd_ready = 1'b1; pixel_valid = 1'b1;
      background_rgb = 24'($urandom); mask_rgb = 24'($urandom);
    end
    check("reach_w2", 32'(found), 32'd1);
    sd_ready = 1'b0; pixel_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("async_rst_wr_req", 32'(sd_wr_req), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_pixel_ready", 32'(pixel_ready), 32'd0);
    check("async_rst_addr", 32'(sd_addr), 32'd0);
    check("async_rst_checksum", 32'(checksum), 32'd0);
    @(negedge clk);
    reset = 1'b0; sd_ready = 1'b1; pixel_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_after_rst_req", 32'(sd_wr_req), 32'd0);
      check("idle_after_rst_ready", 32'(pixel_ready), 32'd0);
    end
    pixel_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; pixel_valid = 1'b0;
    sd_ready = 1'b0; background_rgb = '0; mask_rgb = '0;
    repeat (2) @(negedge clk);
    check("rst_pixel_ready", 32'(pixel_ready), 32'd0);
    check("rst_wr_req", 32'(sd_wr_req), 32'd0);
    check("rst_addr", 32'(sd_addr), 32'd0);
    check("rst_data", 32'(sd_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    reset = 1'b0;

    run_frame(AW'(32'h100), 100, 100, 1'b0, 1'b1);
    run_frame(AW'(32'h100), 40, 100, 1'b0, 1'b1);
    run_frame(AW'(32'h0), 100, 100, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      run_frame(AW'($urandom), 30 + 15 * i, 50 + 10 * i, 1'b0, 1'b0);
    run_frame(AW'(32'h200), 100, 100, 1'b1, 1'b0);
    run_frame(AW'(32'h200), 60, 70, 1'b1, 1'b0);
    run_frame({AW{1'b1}} - AW'(7), 70, 70, 1'b0, 1'b0);
    reset_mid_w2(AW'(32'h40));
    run_frame(AW'(32'h300), 80, 80, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
